// File: rtl/serdes_pkg.sv
// Shared serialiser state type and counter-width helper for pad_serdes_bridge.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    // Width of a counter that spans n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serdes_sync_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of two >= 2.
module serdes_sync_fifo
    import serdes_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign count   = count_reg;
    // The head is visible without a read cycle so the serialiser can chain words gaplessly.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pad_serdes_bridge.sv
// Pad-ring bridge: multi-lane serial-to-parallel input, FIFO-buffered parallel-to-serial output.
// Define SERDES_PARITY_EN to append an even-parity bit after every serialised word.
module pad_serdes_bridge
    import serdes_pkg::*;
#(
    parameter int IN_LANES   = 1,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [IN_LANES-1:0]      in_data,
    output logic                     word_valid,
    output logic [IN_LANES*IN_W-1:0] word_data,
    output logic                     word_partial,
    input  logic                     core_valid,
    output logic                     core_ready,
    input  logic [OUT_W-1:0]         core_data,
    output logic                     out_valid,
    output logic                     out_value
);

    localparam int CNT_W   = cnt_w(IN_W);
    localparam int BCNT_W  = cnt_w(OUT_W);
    localparam int FIFO_AW = cnt_w(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(IN_W - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(OUT_W - 1);

    // ---------------- deserialiser ----------------
    logic [CNT_W-1:0]                cnt_reg;
    logic [CNT_W:0]                  tail_shift;
    logic [IN_LANES-1:0][IN_W-1:0]   sh_reg;
    logic [IN_LANES-1:0][IN_W-1:0]   sh_next;
    logic [IN_LANES-1:0][IN_W-1:0]   tail_word;
    logic [IN_LANES-1:0][IN_W-1:0]   word_reg;
    logic                            word_valid_reg;
    logic                            word_partial_reg;

    // Left-align the cnt received bits of a frame tail; older bits fall off the top.
    assign tail_shift = (CNT_W+1)'(IN_W) - {1'b0, cnt_reg};

    genvar gi;
    generate
        for (gi = 0; gi < IN_LANES; gi++) begin : g_lane
            assign sh_next[gi]   = {sh_reg[gi][IN_W-2:0], in_data[gi]};
            assign tail_word[gi] = sh_reg[gi] << tail_shift;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg          <= '0;
            sh_reg           <= '0;
            word_reg         <= '0;
            word_valid_reg   <= 1'b0;
            word_partial_reg <= 1'b0;
        end else begin
            word_valid_reg   <= 1'b0;
            word_partial_reg <= 1'b0;
            if (in_valid) begin
                sh_reg <= sh_next;
                if (cnt_reg == CNT_LAST) begin
                    cnt_reg        <= '0;
                    word_reg       <= sh_next;
                    word_valid_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else if (cnt_reg != '0) begin
                cnt_reg          <= '0;
                word_reg         <= tail_word;
                word_valid_reg   <= 1'b1;
                word_partial_reg <= 1'b1;
            end
        end
    end

    assign word_valid   = word_valid_reg;
    assign word_data    = word_reg;
    assign word_partial = word_partial_reg;

    // ---------------- output FIFO ----------------
    logic [OUT_W-1:0]   fifo_head;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    assign core_ready = (fifo_count != (FIFO_AW+1)'(FIFO_DEPTH));

    serdes_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (core_valid && !fifo_full),
        .wr_data (core_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- serialiser ----------------
    ser_state_t        state_reg;
    ser_state_t        state_next;
    logic [OUT_W-1:0]  sreg_reg;
    logic [OUT_W-1:0]  sreg_next;
    logic [BCNT_W-1:0] bcnt_reg;
    logic [BCNT_W-1:0] bcnt_next;
    logic              word_done;
`ifdef SERDES_PARITY_EN
    logic              parity_reg;
    logic              parity_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            sreg_reg   <= '0;
            bcnt_reg   <= '0;
`ifdef SERDES_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            sreg_reg   <= sreg_next;
            bcnt_reg   <= bcnt_next;
`ifdef SERDES_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        sreg_next   = sreg_reg;
        bcnt_next   = bcnt_reg;
        fifo_pop    = 1'b0;
        word_done   = 1'b0;
        out_valid   = 1'b0;
        out_value   = 1'b0;
`ifdef SERDES_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_value = sreg_reg[OUT_W-1];
                sreg_next = sreg_reg << 1;
                bcnt_next = bcnt_reg + 1'b1;
                if (bcnt_reg == BCNT_LAST) begin
`ifdef SERDES_PARITY_EN
                    state_next = PARITY;
`else
                    word_done  = 1'b1;
`endif
                end
            end
`ifdef SERDES_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                out_value = parity_reg;
                word_done = 1'b1;
            end
`endif
            default: state_next = IDLE;
        endcase

        // Chaining on the final cycle of a word keeps out_valid continuous.
        if (word_done) begin
            if (!fifo_empty) begin
                fifo_pop   = 1'b1;
                state_next = SHIFT;
            end else begin
                state_next = IDLE;
            end
        end
        if (fifo_pop) begin
            sreg_next   = fifo_head;
            bcnt_next   = '0;
`ifdef SERDES_PARITY_EN
            parity_next = ^fifo_head;
`endif
        end
    end

endmodule
